// File: rtl/exmem_skid_register_if.sv
// EX/MEM handshake bundle: EX-side input payload, MEM-side output payload, flush and hazard tap.
// Latency: none (wires only).
// Backpressure: carries In_Ready/Out_Ready; the register drives In_Ready, MEM drives Out_Ready.
//
// modport slave  : view of the pipeline register (consumes In_*, produces Out_*, Count, Fwd_*)
// modport master : view of the surrounding pipeline (EX, MEM, hazard unit)
interface exmem_skid_register_if #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 4,
    parameter int SIZE_W = 2
);
    logic              FLUSH;

    logic              In_Valid;
    logic              In_Ready;
    logic [SIZE_W-1:0] Size_In;
    logic              Enable_In;
    logic              rw_In;
    logic              Load_In;
    logic              rf_In;
    logic [DATA_W-1:0] RegFile_PortC_In;
    logic [DATA_W-1:0] ALU_In;
    logic [RD_W-1:0]   Rd_In;

    logic              Out_Valid;
    logic              Out_Ready;
    logic [SIZE_W-1:0] Size_Out;
    logic              Enable_Out;
    logic              rw_Out;
    logic              Load_Out;
    logic              rf_Out;
    logic [DATA_W-1:0] RegFile_PortC_Out;
    logic [DATA_W-1:0] ALU_Out;
    logic [RD_W-1:0]   Rd_Out;

    logic [1:0]        Count;
    logic              Fwd_Valid;
    logic [RD_W-1:0]   Fwd_Rd;
    logic [DATA_W-1:0] Fwd_Data;

    modport slave (
        input  FLUSH,
        input  In_Valid, Size_In, Enable_In, rw_In, Load_In, rf_In,
               RegFile_PortC_In, ALU_In, Rd_In,
        output In_Ready,
        output Out_Valid, Size_Out, Enable_Out, rw_Out, Load_Out, rf_Out,
               RegFile_PortC_Out, ALU_Out, Rd_Out,
        input  Out_Ready,
        output Count, Fwd_Valid, Fwd_Rd, Fwd_Data
    );

    modport master (
        output FLUSH,
        output In_Valid, Size_In, Enable_In, rw_In, Load_In, rf_In,
               RegFile_PortC_In, ALU_In, Rd_In,
        input  In_Ready,
        input  Out_Valid, Size_Out, Enable_Out, rw_Out, Load_Out, rf_Out,
               RegFile_PortC_Out, ALU_Out, Rd_Out,
        output Out_Ready,
        input  Count, Fwd_Valid, Fwd_Rd, Fwd_Data
    );
endinterface

// File: rtl/exmem_skid_register.sv
// EX/MEM pipeline register with a two-entry skid buffer, synchronous flush and forwarding tap.
// Latency: 1 cycle from accepted push to *_Out; 1 entry/cycle throughput while Out_Ready is high.
// Backpressure: In_Ready = !skid_valid (register only); absorbs one extra entry after Out_Ready drops.
//
// Ports: CLK (rising edge), CLR_N (async active-low reset), bus (slave modport):
//   In_* payload + In_Valid/In_Ready from EX, Out_* payload + Out_Valid/Out_Ready to MEM,
//   FLUSH, Count (occupancy 0..2), Fwd_Valid/Fwd_Rd/Fwd_Data (from the main entry only).
module exmem_skid_register #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 4,
    parameter int SIZE_W = 2
) (
    input  logic                     CLK,
    input  logic                     CLR_N,
    exmem_skid_register_if.slave     bus
);

    typedef struct packed {
        logic [SIZE_W-1:0] size;
        logic              enable;
        logic              rw;
        logic              load;
        logic              rf;
        logic [DATA_W-1:0] portc;
        logic [DATA_W-1:0] alu;
        logic [RD_W-1:0]   rd;
    } entry_t;

    entry_t in_dat;
    entry_t m_dat;
    entry_t s_dat;
    logic   m_vld;
    logic   s_vld;
    logic   push;
    logic   pop;

    // Clearing the control fields turns an empty main entry into a bubble so MEM
    // never sees a stray enable; data fields are kept to avoid needless toggling.
    function automatic entry_t bubble(input entry_t e);
        entry_t b;
        b        = e;
        b.size   = '0;
        b.enable = 1'b0;
        b.rw     = 1'b0;
        b.load   = 1'b0;
        b.rf     = 1'b0;
        return b;
    endfunction

    assign in_dat = {bus.Size_In, bus.Enable_In, bus.rw_In, bus.Load_In, bus.rf_In,
                     bus.RegFile_PortC_In, bus.ALU_In, bus.Rd_In};

    assign bus.In_Ready  = !s_vld;
    assign push          = bus.In_Valid && !s_vld;
    assign pop           = m_vld && bus.Out_Ready;

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            m_vld <= 1'b0;
            s_vld <= 1'b0;
            m_dat <= '0;
            s_dat <= '0;
        end else if (bus.FLUSH) begin
            // A concurrent pop still completes on the MEM side; nothing new is loaded.
            m_vld <= 1'b0;
            s_vld <= 1'b0;
            m_dat <= bubble(m_dat);
        end else if (!m_vld) begin
            // Skid is always empty here, so a push lands straight in main.
            if (push) begin
                m_vld <= 1'b1;
                m_dat <= in_dat;
            end
        end else if (!s_vld) begin
            if (pop && push) begin
                m_dat <= in_dat;
            end else if (pop) begin
                m_vld <= 1'b0;
                m_dat <= bubble(m_dat);
            end else if (push) begin
                s_vld <= 1'b1;
                s_dat <= in_dat;
            end
        end else if (pop) begin
            // Both full: In_Ready is low, so only the skid-to-main move can happen.
            m_dat <= s_dat;
            s_vld <= 1'b0;
        end
    end

    assign bus.Out_Valid         = m_vld;
    assign bus.Size_Out          = m_dat.size;
    assign bus.Enable_Out        = m_dat.enable;
    assign bus.rw_Out            = m_dat.rw;
    assign bus.Load_Out          = m_dat.load;
    assign bus.rf_Out            = m_dat.rf;
    assign bus.RegFile_PortC_Out = m_dat.portc;
    assign bus.ALU_Out           = m_dat.alu;
    assign bus.Rd_Out            = m_dat.rd;

    assign bus.Count = {1'b0, m_vld} + {1'b0, s_vld};

    // The skid entry is never forwarded: the hazard unit stalls EX while In_Ready is low.
    assign bus.Fwd_Valid = m_vld && m_dat.rf;
    assign bus.Fwd_Rd    = m_dat.rd;
    assign bus.Fwd_Data  = m_dat.alu;

endmodule

// File: tb/tb_exmem_skid_register.sv
module tb_exmem_skid_register;
    localparam int DW = 64;
    localparam int RW = 5;
    localparam int SW = 2;

    logic clk   = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    exmem_skid_register_if #(.DATA_W(DW), .RD_W(RW), .SIZE_W(SW)) bus ();

    exmem_skid_register #(.DATA_W(DW), .RD_W(RW), .SIZE_W(SW)) dut (
        .CLK   (clk),
        .CLR_N (clr_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [SW-1:0] size;
        logic          en;
        logic          rw;
        logic          ld;
        logic          rf;
        logic [DW-1:0] pc;
        logic [DW-1:0] alu;
        logic [RW-1:0] rd;
    } ent_t;

    typedef struct {
        logic          iv;
        logic          orr;
        logic          fl;
        logic          rf;
        logic [DW-1:0] alu;
        logic [RW-1:0] rd;
        logic          e_vld;
        logic [1:0]    e_cnt;
        logic          e_inr;
        logic          e_fvld;
        logic [DW-1:0] e_alu;
        logic [RW-1:0] e_rd;
    } vec_t;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic orr, input logic fl, input ent_t e);
        bus.In_Valid         = iv;
        bus.Out_Ready        = orr;
        bus.FLUSH            = fl;
        bus.Size_In          = e.size;
        bus.Enable_In        = e.en;
        bus.rw_In            = e.rw;
        bus.Load_In          = e.ld;
        bus.rf_In            = e.rf;
        bus.RegFile_PortC_In = e.pc;
        bus.ALU_In           = e.alu;
        bus.Rd_In            = e.rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t v(input logic iv, input logic orr, input logic fl, input logic rf,
                               input logic [DW-1:0] alu, input logic [RW-1:0] rd,
                               input logic e_vld, input logic [1:0] e_cnt, input logic e_inr,
                               input logic e_fvld, input logic [DW-1:0] e_alu,
                               input logic [RW-1:0] e_rd);
        vec_t r;
        r.iv = iv; r.orr = orr; r.fl = fl; r.rf = rf; r.alu = alu; r.rd = rd;
        r.e_vld = e_vld; r.e_cnt = e_cnt; r.e_inr = e_inr; r.e_fvld = e_fvld;
        r.e_alu = e_alu; r.e_rd = e_rd;
        return r;
    endfunction

    vec_t tbl[15];
    ent_t q[$];

    initial begin
        ent_t e;
        ent_t z;
        logic ir0;
        bit   m_push;
        bit   m_pop;
        logic iv;
        logic orr;
        logic fl;

        z = '{default: '0};
        drive(1'b0, 1'b0, 1'b0, z);

        //        iv orr fl rf alu       rd   | vld cnt inr fvld alu      rd
        tbl[0]  = v(1, 1, 0, 0, 64'h1,    0,    1, 1, 1, 0, 64'h1,    0); // stream 1,2,3
        tbl[1]  = v(1, 1, 0, 0, 64'h2,    0,    1, 1, 1, 0, 64'h2,    0);
        tbl[2]  = v(1, 1, 0, 0, 64'h3,    0,    1, 1, 1, 0, 64'h3,    0);
        tbl[3]  = v(0, 1, 0, 0, 64'h0,    0,    0, 0, 1, 0, 64'h3,    0); // drain, data holds
        tbl[4]  = v(1, 0, 0, 0, 64'h10,   0,    1, 1, 1, 0, 64'h10,   0); // backpressure
        tbl[5]  = v(1, 0, 0, 0, 64'h20,   0,    1, 2, 0, 0, 64'h10,   0);
        tbl[6]  = v(0, 1, 0, 0, 64'h0,    0,    1, 1, 1, 0, 64'h20,   0);
        tbl[7]  = v(0, 1, 0, 0, 64'h0,    0,    0, 0, 1, 0, 64'h20,   0);
        tbl[8]  = v(1, 0, 0, 0, 64'h30,   0,    1, 1, 1, 0, 64'h30,   0); // fill then flush
        tbl[9]  = v(1, 0, 0, 0, 64'h40,   0,    1, 2, 0, 0, 64'h30,   0);
        tbl[10] = v(1, 0, 1, 0, 64'h50,   0,    0, 0, 1, 0, 64'h30,   0);
        tbl[11] = v(0, 1, 0, 0, 64'h0,    0,    0, 0, 1, 0, 64'h30,   0);
        tbl[12] = v(1, 1, 1, 0, 64'h60,   0,    0, 0, 1, 0, 64'h30,   0); // flush beats ready push
        tbl[13] = v(1, 0, 0, 1, 64'hABCD, 5,    1, 1, 1, 1, 64'hABCD, 5); // forwarding tap
        tbl[14] = v(0, 1, 0, 0, 64'h0,    0,    0, 0, 1, 0, 64'hABCD, 5);

        // Reset values while CLR_N is held low
        #12;
        chk("rst_out_valid", bus.Out_Valid, 0);
        chk("rst_count",     bus.Count, 0);
        chk("rst_in_ready",  bus.In_Ready, 1);
        chk("rst_alu_out",   bus.ALU_Out, 0);
        chk("rst_enable",    bus.Enable_Out, 0);
        chk("rst_fwd_valid", bus.Fwd_Valid, 0);
        clr_n = 1'b1;
        tick();
        chk("post_rst_in_ready", bus.In_Ready, 1);

        for (int i = 0; i < 15; i++) begin
            e = z;
            e.en  = tbl[i].iv;
            e.rf  = tbl[i].rf;
            e.alu = tbl[i].alu;
            e.rd  = tbl[i].rd;
            drive(tbl[i].iv, tbl[i].orr, tbl[i].fl, e);
            tick();
            chk($sformatf("vec%0d_out_valid", i), bus.Out_Valid, tbl[i].e_vld);
            chk($sformatf("vec%0d_count", i),     bus.Count, tbl[i].e_cnt);
            chk($sformatf("vec%0d_in_ready", i),  bus.In_Ready, tbl[i].e_inr);
            chk($sformatf("vec%0d_alu_out", i),   bus.ALU_Out, tbl[i].e_alu);
            chk($sformatf("vec%0d_enable", i),    bus.Enable_Out, tbl[i].e_vld);
            chk($sformatf("vec%0d_rf_out", i),    bus.rf_Out, tbl[i].e_fvld);
            chk($sformatf("vec%0d_fwd_valid", i), bus.Fwd_Valid, tbl[i].e_fvld);
            chk($sformatf("vec%0d_fwd_rd", i),    bus.Fwd_Rd, tbl[i].e_rd);
            chk($sformatf("vec%0d_fwd_data", i),  bus.Fwd_Data, tbl[i].e_alu);
        end

        // Asynchronous reset with both entries full
        e = z; e.en = 1'b1; e.alu = 64'h70;
        drive(1'b1, 1'b0, 1'b0, e);
        tick();
        e.alu = 64'h80;
        drive(1'b1, 1'b0, 1'b0, e);
        tick();
        chk("pre_arst_count", bus.Count, 2);
        drive(1'b0, 1'b0, 1'b0, z);
        #3 clr_n = 1'b0;
        #1;
        chk("arst_out_valid", bus.Out_Valid, 0);
        chk("arst_count",     bus.Count, 0);
        chk("arst_alu_out",   bus.ALU_Out, 0);
        chk("arst_enable",    bus.Enable_Out, 0);
        chk("arst_in_ready",  bus.In_Ready, 1);
        #2 clr_n = 1'b1;
        tick();
        chk("arst_rel_count",    bus.Count, 0);
        chk("arst_rel_in_ready", bus.In_Ready, 1);
        chk("arst_rel_valid",    bus.Out_Valid, 0);

        // Randomised traffic against an in-order queue model
        q.delete();
        for (int c = 0; c < 10000; c++) begin
            iv  = ($urandom_range(0, 99) < 70);
            orr = ($urandom_range(0, 99) < (((c / 1000) % 2 == 1) ? 30 : 85));
            fl  = ($urandom_range(0, 199) == 0);
            e.size = SW'($urandom);
            e.en   = 1'($urandom);
            e.rw   = 1'($urandom);
            e.ld   = 1'($urandom);
            e.rf   = 1'($urandom);
            e.pc   = {$urandom, $urandom};
            e.alu  = {$urandom, $urandom};
            e.rd   = RW'($urandom);
            drive(iv, orr, fl, e);
            m_push = iv && (q.size() < 2);
            m_pop  = orr && (q.size() > 0);

            if (c % 8 == 0) begin
                ir0 = bus.In_Ready;
                bus.Out_Ready = ~orr;
                bus.In_Valid  = ~iv;
                #1;
                chk("in_ready_comb", bus.In_Ready, ir0);
                bus.Out_Ready = orr;
                bus.In_Valid  = iv;
            end

            tick();
            if (fl) begin
                q.delete();
            end else begin
                if (m_pop)  void'(q.pop_front());
                if (m_push) q.push_back(e);
            end

            chk("rnd_out_valid", bus.Out_Valid, (q.size() > 0));
            chk("rnd_count",     bus.Count, q.size());
            chk("rnd_in_ready",  bus.In_Ready, (q.size() < 2));
            if (q.size() > 0) begin
                chk("rnd_alu",    bus.ALU_Out, q[0].alu);
                chk("rnd_portc",  bus.RegFile_PortC_Out, q[0].pc);
                chk("rnd_rd",     bus.Rd_Out, q[0].rd);
                chk("rnd_ctrl",   {bus.Size_Out, bus.Enable_Out, bus.rw_Out, bus.Load_Out, bus.rf_Out},
                                  {q[0].size, q[0].en, q[0].rw, q[0].ld, q[0].rf});
                chk("rnd_fwd_valid", bus.Fwd_Valid, q[0].rf);
            end else begin
                chk("rnd_bubble_ctrl", {bus.Size_Out, bus.Enable_Out, bus.rw_Out, bus.Load_Out, bus.rf_Out}, 0);
                chk("rnd_bubble_fwd",  bus.Fwd_Valid, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
